// File: rtl/fmiller_pkg.sv
// Shared types and constants for the FM/Miller receive path.
package fmiller_pkg;

  // Receive sequencer states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HUNT    = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  // Default sync pattern, MSB received first.
  localparam logic [15:0] SYNC_WORD_DEF = 16'h2DD4;

  // Bit order on air for length and payload bytes.
  localparam bit MSB_FIRST = 1'b1;

endpackage

// File: rtl/fmiller_rx_ctrl_if.sv
// Byte stream and frame status between the receive sequencer and its consumer.
interface fmiller_rx_ctrl_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] frame_len;
  logic       frame_start;
  logic       frame_done;
  logic       frame_err;
  logic       busy;

  modport master (
    output byte_data, byte_valid, frame_len, frame_start, frame_done, frame_err, busy,
    input  byte_ready
  );

  modport slave (
    input  byte_data, byte_valid, frame_len, frame_start, frame_done, frame_err, busy,
    output byte_ready
  );
endinterface

// File: rtl/fmiller_sync_det.sv
// Sync word hunter: shifts one sample per strobe and flags a match on the
// value the register would hold after this shift.
module fmiller_sync_det
  import fmiller_pkg::*;
#(
  parameter int                SYNC_W    = 16,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(SYNC_WORD_DEF)
) (
  input  logic clk2x,
  input  logic rst_n,
  input  logic clr,
  input  logic stb,
  input  logic bit_in,
  output logic match
);

  // Only SYNC_W-1 history bits are needed; the newest bit completes the word.
  logic [SYNC_W-2:0] sreg;
  logic [SYNC_W-1:0] shifted;

  assign shifted = {sreg, bit_in};
  assign match   = stb && !clr && (shifted == SYNC_WORD);

  // History register: cleared while not hunting, shifts on each sample.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk2x or negedge rst_n) begin
    if (!rst_n)     sreg <= '0;
    else if (clr)   sreg <= '0;
    else if (stb)   sreg <= shifted[SYNC_W-2:0];
  end

endmodule

// File: rtl/fmiller_rx_ctrl.sv
// Receive-side sequencer: hunts sync, reads a length byte, streams payload
// bytes out on valid/ready and reports frame start/done/error.
module fmiller_rx_ctrl
  import fmiller_pkg::*;
#(
  parameter int                SYNC_W    = 16,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(SYNC_WORD_DEF),
  parameter int                MAX_LEN   = 32
) (
  input  logic clk2x,
  input  logic rst_n,
  input  logic rx_en,
  input  logic dec_bit,
  output logic dec_en,
  fmiller_rx_ctrl_if.master bus
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t     state, state_nx;
  logic       phase;
  logic [2:0] bit_cnt;
  logic [7:0] byte_cnt;
  logic [6:0] shreg;
  logic [7:0] samp_byte;
  logic [7:0] frame_len_q, byte_data_q;
  logic       byte_valid_q, start_q, done_q, err_q;
  logic       match, last_bit, xfer, load, collecting, busy_w;
  logic       start_nx, done_nx, err_nx;

  assign busy_w     = state inside {LEN, PAYLOAD, DRAIN};
  assign collecting = state inside {LEN, PAYLOAD};
  assign last_bit   = phase && (bit_cnt == 3'd7);
  assign xfer       = byte_valid_q && bus.byte_ready;
  // Byte as it stands once the current sample is shifted in.
  assign samp_byte  = MSB_FIRST ? {shreg, dec_bit} : {dec_bit, shreg};

  fmiller_sync_det #(.SYNC_W(SYNC_W), .SYNC_WORD(SYNC_WORD)) u_sync_det (
    .clk2x  (clk2x),
    .rst_n  (rst_n),
    .clr    (state != HUNT),
    .stb    (phase),
    .bit_in (dec_bit),
    .match  (match)
  );

  // State register.
  always_ff @(posedge clk2x or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and the event strobes that drive the datapath and pulses.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    start_nx = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    load     = 1'b0;
    case (state)
      IDLE:    if (rx_en) state_nx = HUNT;
      HUNT:    if (match) begin
                 start_nx = 1'b1;
                 state_nx = LEN;
               end
      LEN:     if (last_bit) begin
                 if (samp_byte == 8'd0 || samp_byte > MAX_LEN_B) begin
                   err_nx   = 1'b1;
                   state_nx = HUNT;
                 end else begin
                   state_nx = PAYLOAD;
                 end
               end
      PAYLOAD: if (last_bit) begin
                 // A transfer this edge frees the hold register for the new byte.
                 if (!byte_valid_q || bus.byte_ready) begin
                   load = 1'b1;
                   if (byte_cnt == 8'd1) state_nx = DRAIN;
                 end else begin
                   err_nx   = 1'b1;
                   state_nx = HUNT;
                 end
               end
      DRAIN:   if (xfer) begin
                 done_nx  = 1'b1;
                 state_nx = HUNT;
               end
      default: state_nx = IDLE;
    endcase
    // Software disable overrides everything; a frame in flight is an abort.
    if (!rx_en) begin
      state_nx = IDLE;
      start_nx = 1'b0;
      done_nx  = 1'b0;
      load     = 1'b0;
      err_nx   = busy_w;
    end
  end

  // Bit timing, sample assembly, counters, hold register and pulses.
  always_ff @(posedge clk2x or negedge rst_n) begin
    if (!rst_n) begin
      phase        <= 1'b0;
      dec_en       <= 1'b0;
      bit_cnt      <= '0;
      byte_cnt     <= '0;
      shreg        <= '0;
      frame_len_q  <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      start_q      <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      phase  <= (state == IDLE) ? 1'b0 : ~phase;
      dec_en <= (state != IDLE);

      if (collecting) begin
        if (phase) begin
          shreg   <= MSB_FIRST ? samp_byte[6:0] : samp_byte[7:1];
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else begin
        bit_cnt <= '0;
      end

      if (state == LEN && state_nx == PAYLOAD) begin
        frame_len_q <= samp_byte;
        byte_cnt    <= samp_byte;
      end else if (load) begin
        byte_cnt <= byte_cnt - 8'd1;
      end

      if (!rx_en) begin
        byte_valid_q <= 1'b0;
        byte_data_q  <= '0;
      end else if (load) begin
        byte_data_q  <= samp_byte;
        byte_valid_q <= 1'b1;
      end else if (xfer) begin
        byte_valid_q <= 1'b0;
      end

      // frame_err outranks done, done outranks start.
      err_q   <= err_nx;
      done_q  <= done_nx && !err_nx;
      start_q <= start_nx && !err_nx && !done_nx;
    end
  end

  assign bus.byte_data   = byte_data_q;
  assign bus.byte_valid  = byte_valid_q;
  assign bus.frame_len   = frame_len_q;
  assign bus.frame_start = start_q;
  assign bus.frame_done  = done_q;
  assign bus.frame_err   = err_q;
  assign bus.busy        = busy_w;

endmodule

// File: tb/tb_fmiller_rx_ctrl.sv
// Directed bench for fmiller_rx_ctrl: drives bit streams at half clk2x rate
// and checks frame pulses, byte stream and status against hand values.
module tb_fmiller_rx_ctrl;

  logic clk2x   = 1'b0;
  logic rst_n   = 1'b1;
  logic rx_en   = 1'b0;
  logic dec_bit = 1'b0;
  logic dec_en;

  fmiller_rx_ctrl_if bus_if ();

  fmiller_rx_ctrl #(.SYNC_W(16), .SYNC_WORD(16'h2DD4), .MAX_LEN(32)) dut (
    .clk2x   (clk2x),
    .rst_n   (rst_n),
    .rx_en   (rx_en),
    .dec_bit (dec_bit),
    .dec_en  (dec_en),
    .bus     (bus_if)
  );

  always #5 clk2x = ~clk2x;

  int total = 0;
  int bad   = 0;
  int n_start, n_done, n_err, n_bv;
  int n_multi = 0;
  logic [7:0] got[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Pulse / transfer monitor, sampled mid-cycle.
  always @(negedge clk2x) begin
    #1;
    if (bus_if.frame_start) n_start++;
    if (bus_if.frame_done)  n_done++;
    if (bus_if.frame_err)   n_err++;
    if (bus_if.byte_valid)  n_bv++;
    if (bus_if.byte_valid && bus_if.byte_ready) got.push_back(bus_if.byte_data);
    if (int'(bus_if.frame_start) + int'(bus_if.frame_done) + int'(bus_if.frame_err) > 1) n_multi++;
  end

  task automatic clear_mon();
    n_start = 0; n_done = 0; n_err = 0; n_bv = 0;
    got.delete();
  endtask

  // Each bit is held for two clk2x edges, so exactly one edge samples it.
  task automatic send_bit(input logic b);
    @(negedge clk2x);
    dec_bit = b;
    @(negedge clk2x);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_sync(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic idle_bits(input int n);
    repeat (n) send_bit(1'b0);
  endtask

  task automatic settle();
    @(negedge clk2x);
    #2;
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] exp[$]);
    check({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) check($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp[i]));
    end
  endtask

  initial begin
    bus_if.byte_ready = 1'b0;
    clear_mon();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk2x);
    #2;
    check("rst_dec_en",      32'(dec_en), 0);
    check("rst_byte_valid",  32'(bus_if.byte_valid), 0);
    check("rst_busy",        32'(bus_if.busy), 0);
    check("rst_frame_len",   32'(bus_if.frame_len), 0);
    check("rst_pulses",      32'({bus_if.frame_start, bus_if.frame_done, bus_if.frame_err}), 0);
    rst_n = 1'b1;

    // 1: enable, dec_en follows two cycles later, idle line gives nothing.
    @(negedge clk2x); rx_en = 1'b1;
    @(negedge clk2x); #2;
    check("t1_dec_en_lag", 32'(dec_en), 0);
    @(negedge clk2x); #2;
    check("t1_dec_en", 32'(dec_en), 1);
    idle_bits(20); settle();
    check("t1_start", 32'(n_start), 0);
    check("t1_err",   32'(n_err), 0);
    check("t1_busy",  32'(bus_if.busy), 0);

    // 2: good frame, three bytes, consumer always ready.
    clear_mon();
    bus_if.byte_ready = 1'b1;
    send_sync(16'h2DD4);
    send_byte(8'h03);
    send_byte(8'hA5);
    check("t2_frame_len", 32'(bus_if.frame_len), 3);
    check("t2_busy_mid",  32'(bus_if.busy), 1);
    send_byte(8'h3C);
    send_byte(8'hFF);
    idle_bits(4); settle();
    check("t2_start", 32'(n_start), 1);
    check("t2_done",  32'(n_done), 1);
    check("t2_err",   32'(n_err), 0);
    check_bytes("t2", '{8'hA5, 8'h3C, 8'hFF});
    check("t2_busy_end", 32'(bus_if.busy), 0);
    check("t2_dec_en",   32'(dec_en), 1);

    // 3a: zero length.
    clear_mon();
    send_sync(16'h2DD4);
    send_byte(8'h00);
    idle_bits(4); settle();
    check("t3a_start", 32'(n_start), 1);
    check("t3a_err",   32'(n_err), 1);
    check("t3a_bv",    32'(n_bv), 0);
    check("t3a_busy",  32'(bus_if.busy), 0);

    // 3b: length one above the maximum.
    clear_mon();
    send_sync(16'h2DD4);
    send_byte(8'h21);
    idle_bits(4); settle();
    check("t3b_start", 32'(n_start), 1);
    check("t3b_err",   32'(n_err), 1);
    check("t3b_bv",    32'(n_bv), 0);

    // 4: consumer stalled, second byte overflows the hold register.
    clear_mon();
    bus_if.byte_ready = 1'b0;
    send_sync(16'h2DD4);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    idle_bits(4); settle();
    check("t4_err",        32'(n_err), 1);
    check("t4_done",       32'(n_done), 0);
    check("t4_held_valid", 32'(bus_if.byte_valid), 1);
    check("t4_held_data",  32'(bus_if.byte_data), 32'h11);
    check("t4_busy",       32'(bus_if.busy), 0);
    @(negedge clk2x); bus_if.byte_ready = 1'b1;
    @(negedge clk2x); bus_if.byte_ready = 1'b0;
    #2;
    check_bytes("t4", '{8'h11});
    check("t4_valid_after", 32'(bus_if.byte_valid), 0);

    // 5: disable in the middle of a payload with a byte pending.
    clear_mon();
    send_sync(16'h2DD4);
    send_byte(8'h04);
    send_byte(8'h5A);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    #2;
    check("t5_pend_valid", 32'(bus_if.byte_valid), 1);
    check("t5_pend_data",  32'(bus_if.byte_data), 32'h5A);
    check("t5_busy_pre",   32'(bus_if.busy), 1);
    @(negedge clk2x); rx_en = 1'b0;
    @(negedge clk2x); #2;
    check("t5_err_pulse", 32'(bus_if.frame_err), 1);
    check("t5_valid",     32'(bus_if.byte_valid), 0);
    check("t5_data",      32'(bus_if.byte_data), 0);
    check("t5_busy",      32'(bus_if.busy), 0);
    @(negedge clk2x); #2;
    check("t5_err_gone", 32'(bus_if.frame_err), 0);
    check("t5_dec_en",   32'(dec_en), 0);
    check("t5_err_cnt",  32'(n_err), 1);

    // 6: near-miss sync, then a good one-byte frame.
    clear_mon();
    bus_if.byte_ready = 1'b1;
    @(negedge clk2x); rx_en = 1'b1;
    idle_bits(4);
    send_sync(16'h2DD5);
    idle_bits(8); settle();
    check("t6_no_start", 32'(n_start), 0);
    send_sync(16'h2DD4);
    send_byte(8'h01);
    send_byte(8'hC3);
    idle_bits(4); settle();
    check("t6_start", 32'(n_start), 1);
    check("t6_done",  32'(n_done), 1);
    check("t6_err",   32'(n_err), 0);
    check_bytes("t6", '{8'hC3});

    check("pulse_overlap", 32'(n_multi), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
